// File: rtl/time_set_ctrl.sv
// time_set_ctrl: freezes the clock core, edits hour/min/sec in shadow
// registers from debounced buttons, and commits them with a one-cycle load.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | core counting, buttons other than set ignored
//   ST_SET_H  | editing hour shadow, core frozen
//   ST_SET_M  | editing minute shadow, core frozen
//   ST_SET_S  | editing second shadow, core frozen
//   ST_COMMIT | single cycle, load strobe to core, always returns to RUN
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic [1:0] field,
    output logic [2:0] blank
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam logic [5:0] C_TIMEOUT = 6'(TIMEOUT_S);

    state_t     r_state;
    logic       r_prev_set;
    logic       r_prev_next;
    logic       r_prev_inc;
    logic       r_prev_dec;
    logic       r_armed;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic [5:0] r_idle;
    logic       r_phase;

    state_t     w_state_nxt;
    logic [4:0] w_hour_nxt;
    logic [5:0] w_min_nxt;
    logic [5:0] w_sec_nxt;
    logic [5:0] w_idle_nxt;
    logic       w_phase_nxt;

    logic       w_edge_set;
    logic       w_edge_next;
    logic       w_edge_inc;
    logic       w_edge_dec;
    logic       w_any_edge;
    logic       w_inc_only;
    logic       w_dec_only;
    logic [5:0] w_idle_inc;

    function automatic logic [4:0] hour_up(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_dn(input logic [4:0] h);
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] ms_up(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] ms_dn(input logic [5:0] v);
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    // Edges are masked for the first cycle after reset so that a button
    // already held high when reset releases is not taken as a press.
    assign w_edge_set  = r_armed & btn_set  & ~r_prev_set;
    assign w_edge_next = r_armed & btn_next & ~r_prev_next;
    assign w_edge_inc  = r_armed & btn_inc  & ~r_prev_inc;
    assign w_edge_dec  = r_armed & btn_dec  & ~r_prev_dec;
    assign w_any_edge  = w_edge_set | w_edge_next | w_edge_inc | w_edge_dec;
    assign w_inc_only  = w_edge_inc & ~w_edge_dec;
    assign w_dec_only  = w_edge_dec & ~w_edge_inc;
    assign w_idle_inc  = (r_idle == 6'h3f) ? r_idle : r_idle + 6'd1;

    // Button history flops and the post-reset arming flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_set  <= 1'b0;
            r_prev_next <= 1'b0;
            r_prev_inc  <= 1'b0;
            r_prev_dec  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_prev_set  <= btn_set;
            r_prev_next <= btn_next;
            r_prev_inc  <= btn_inc;
            r_prev_dec  <= btn_dec;
            r_armed     <= 1'b1;
        end
    end

    // State, shadow, idle counter and blink phase registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_hour  <= 5'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_idle  <= 6'd0;
            r_phase <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hour  <= w_hour_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_idle  <= w_idle_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next-state and shadow update; buttons take priority over the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_idle_nxt  = r_idle;
        w_phase_nxt = r_phase;

        case (r_state)
            ST_RUN: begin
                if (w_edge_set) begin
                    w_hour_nxt  = cur_hour;
                    w_min_nxt   = cur_min;
                    w_sec_nxt   = cur_sec;
                    w_idle_nxt  = 6'd0;
                    w_phase_nxt = 1'b1;
                    w_state_nxt = ST_SET_H;
                end
            end

            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (w_any_edge) begin
                    w_idle_nxt  = 6'd0;
                    w_phase_nxt = 1'b1;
                    if (w_edge_set) begin
                        w_state_nxt = ST_COMMIT;
                    end else if (w_edge_next) begin
                        case (r_state)
                            ST_SET_H: w_state_nxt = ST_SET_M;
                            ST_SET_M: w_state_nxt = ST_SET_S;
                            default:  w_state_nxt = ST_SET_H;
                        endcase
                    end else if (w_inc_only) begin
                        case (r_state)
                            ST_SET_H: w_hour_nxt = hour_up(r_hour);
                            ST_SET_M: w_min_nxt  = ms_up(r_min);
                            default:  w_sec_nxt  = ms_up(r_sec);
                        endcase
                    end else if (w_dec_only) begin
                        case (r_state)
                            ST_SET_H: w_hour_nxt = hour_dn(r_hour);
                            ST_SET_M: w_min_nxt  = ms_dn(r_min);
                            default:  w_sec_nxt  = ms_dn(r_sec);
                        endcase
                    end
                end else if (tick_1hz) begin
                    w_phase_nxt = ~r_phase;
                    w_idle_nxt  = w_idle_inc;
                    // Abandon the edit without a load; core resumes from its frozen time.
                    if (w_idle_inc >= C_TIMEOUT) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_COMMIT: begin
                w_state_nxt = ST_RUN;
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        run_en = 1'b0;
        load   = 1'b0;
        field  = 2'd3;
        blank  = 3'b000;
        case (r_state)
            ST_RUN: begin
                run_en = 1'b1;
            end
            ST_SET_H: begin
                field = 2'd0;
                blank = {~r_phase, 2'b00};
            end
            ST_SET_M: begin
                field = 2'd1;
                blank = {1'b0, ~r_phase, 1'b0};
            end
            ST_SET_S: begin
                field = 2'd2;
                blank = {2'b00, ~r_phase};
            end
            ST_COMMIT: begin
                load = 1'b1;
            end
            default: begin
                run_en = 1'b1;
            end
        endcase
    end

    assign load_hour = r_hour;
    assign load_min  = r_min;
    assign load_sec  = r_sec;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the clock core's time-setting operation. It freezes the running clock, lets the user edit hour, minute and second in shadow registers with debounced push-buttons, and commits the edited time to the core with a one-cycle load strobe. It also drives per-field blank flags for the display path. It sits between the button inputs and the clock core, alongside the 1 Hz divider.

## Interface
- TIMEOUT_S, default 10: seconds of button inactivity in a set state before the edit is abandoned (range 2..63).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- tick_1hz  in  1  one-clk-wide pulse at 1 Hz from the divider.
- btn_set  in  1  debounced level; a rising edge enters or commits set mode.
- btn_next  in  1  debounced level; a rising edge advances the edited field.
- btn_inc  in  1  debounced level; a rising edge increments the field.
- btn_dec  in  1  debounced level; a rising edge decrements the field.
- cur_hour  in  5  core hour (0..23), captured on entry to set mode.
- cur_min  in  6  core minute (0..59).
- cur_sec  in  6  core second (0..59).
- run_en  out  1  core counting enable; 1 only in RUN.
- load  out  1  one-cycle strobe; the core loads load_* on this cycle.
- load_hour  out  5  shadow hour.
- load_min  out  6  shadow minute.
- load_sec  out  6  shadow second.
- field  out  2  edited field: 0 = hour, 1 = min, 2 = sec, 3 = none (RUN).
- blank  out  3  {hour, min, sec} blank flags for the display; active high.

## Operation
- Edge detection: each button has a registered previous-value flop. An edge is `btn & ~prev`. All prev flops reset to 0.
- States are RUN, SET_H, SET_M, SET_S and COMMIT.
- RUN:
  - run_en = 1, field = 3, blank = 000.
  - A set edge copies cur_* into the shadows, clears the idle counter, sets the blink phase to 1 and moves to SET_H.
  - next, inc and dec edges are ignored.
- SET_H / SET_M / SET_S: run_en = 0.
  - Button priority on the same cycle is set > next > inc/dec.
  - A set edge moves to COMMIT.
  - A next edge moves SET_H → SET_M → SET_S → SET_H.
  - An inc edge alone adds 1 to the field. Hour wraps 23 → 0; min and sec wrap 59 → 0.
  - A dec edge alone subtracts 1. Hour wraps 0 → 23; min and sec wrap 0 → 59.
  - inc and dec edges on the same cycle leave the shadow unchanged but still count as activity.
  - Any accepted edge clears the idle counter and sets the blink phase to 1.
- Blink and timeout:
  - On each tick_1hz with no button edge, the blink phase toggles and the idle counter increments.
  - If the counter reaches TIMEOUT_S, the block returns to RUN with no load strobe. The shadows hold their values and the core resumes from its frozen time.
  - In a set state, the blank bit of the current field is ~phase; the other bits are 0.
- COMMIT:
  - Lasts exactly one cycle, with load = 1, run_en = 0 and field = 3.
  - All button edges are ignored.
  - The next state is always RUN.
- The idle counter is 6 bits and saturates; it never wraps.

## Timing
- Reset values: state RUN, run_en 1, load 0, load_* 0, field 3, blank 000, phase 1, idle 0, prev flops 0.
- Reset asserted mid-edit returns to RUN immediately and asynchronously. No load is issued.
- Button response: an edge sampled at rising edge k updates state and shadows at edge k. The outputs reflect the change in the cycle after k.
- Entry latency: the set edge at k gives run_en = 0 from k onward. Because the capture happens at k, a tick at k is still counted by the core.
- Commit: the set edge at k puts load = 1 for cycle k..k+1, with run_en = 0. At k+1 run_en returns to 1. The core's first count comes from the next tick_1hz after k+1.
- A button held high produces exactly one edge; there is no auto-repeat.
- tick_1hz together with a button edge on the same cycle: the button wins. The idle counter clears and the phase is set to 1; there is no toggle.
- Timeout: with no edges, the transition to RUN happens at the TIMEOUT_S-th tick after the last activity.

## Test plan
- Reset, then cur = 12:34:56 and a set pulse: field = 0, run_en = 0, load_* = 12/34/56, blank = 000 until the first tick, then 100.
- From SET_H at hour 23, inc gives 0. From 0, dec gives 23. Then next, and min 0 with dec gives 59. Then next, and sec 59 with inc gives 0.
- Edit to 07:08:09, then a set pulse: exactly one load cycle with 07/08/09, field = 3 during it, run_en = 1 on the following cycle.
- Enter set mode, then 10 ticks with no buttons (TIMEOUT_S = 10): RUN after the 10th tick, load never asserted, run_en = 1.
- Same-cycle set + inc in SET_M: COMMIT with the minute unchanged. Same-cycle inc + dec: no change, and the idle counter cleared.
- Reset asserted while in SET_S: outputs take their reset values immediately with no load. Button held high across reset release: no edge is detected.
